// File: rtl/fb_cell_writer_if.sv
// Cell-stream handshake and frame-RAM port-A write bus shared by the cell
// producer (master) and fb_cell_writer (slave).
interface fb_cell_writer_if #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 16
) ();
    logic              cell_valid;
    logic              cell_bit;
    logic              cell_last;
    logic              cell_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output cell_valid, cell_bit, cell_last,
        input  cell_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  cell_valid, cell_bit, cell_last,
        output cell_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/fb_cell_writer.sv
// Packs a serial cell-bit stream into 20-pixel words and writes one full
// 1280x1024 frame into the frame RAM per frame_start pulse.
module fb_cell_writer #(
    parameter int DATA_W        = 20,
    parameter int ADDR_W        = 16,
    parameter int WORDS_PER_ROW = 64,
    parameter int ROWS          = 1024
) (
    input  logic                clk108,
    input  logic                reset_n,
    input  logic                frame_start,
    fb_cell_writer_if.slave     bus,
    output logic [9:0]          row_count,
    output logic                busy,
    output logic                frame_done
);
    localparam int COL_W = $clog2(WORDS_PER_ROW);

    typedef enum logic [1:0] {IDLE, FILL, PAD, DONE} state_t;

    state_t            state_q,      state_d;
    logic [4:0]        bit_cnt_q,    bit_cnt_d;
    logic [ADDR_W-1:0] word_addr_q,  word_addr_d;
    logic [9:0]        row_count_q,  row_count_d;
    logic [DATA_W-1:0] shift_q,      shift_d;
    logic              wr_en_q,      wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,    wr_data_d;
    logic              frame_done_q, frame_done_d;

    logic [DATA_W-1:0] packed_word;
    logic              row_end;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_addr_d  = word_addr_q;
        row_count_d  = row_count_q;
        shift_d      = shift_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;

        // Bit 0 is the leftmost pixel; upper bits stay 0 until filled.
        packed_word = shift_q | (DATA_W'(bus.cell_bit) << bit_cnt_q);
        row_end     = (word_addr_q[COL_W-1:0] == COL_W'(WORDS_PER_ROW - 1));

        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d     = FILL;
                    bit_cnt_d   = '0;
                    word_addr_d = '0;
                    row_count_d = '0;
                    shift_d     = '0;
                end
            end
            FILL: begin
                if (bus.cell_valid) begin
                    if (bit_cnt_q == 5'(DATA_W - 1) || bus.cell_last) begin
                        wr_en_d     = 1'b1;
                        wr_addr_d   = word_addr_q;
                        wr_data_d   = packed_word;
                        shift_d     = '0;
                        bit_cnt_d   = '0;
                        word_addr_d = word_addr_q + 1'b1;
                        if (row_end) begin
                            row_count_d = row_count_q + 1'b1;
                            if (row_count_q == 10'(ROWS - 1)) state_d = DONE;
                        end else if (bus.cell_last) begin
                            state_d = PAD;
                        end
                    end else begin
                        shift_d   = packed_word;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PAD: begin
                wr_en_d     = 1'b1;
                wr_addr_d   = word_addr_q;
                wr_data_d   = '0;
                word_addr_d = word_addr_q + 1'b1;
                if (row_end) begin
                    row_count_d = row_count_q + 1'b1;
                    state_d     = (row_count_q == 10'(ROWS - 1)) ? DONE : FILL;
                end
            end
            DONE: begin
                // Registered so the pulse lands one cycle after the final write.
                frame_done_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk108 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            word_addr_q  <= '0;
            row_count_q  <= '0;
            shift_q      <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_addr_q  <= word_addr_d;
            row_count_q  <= row_count_d;
            shift_q      <= shift_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.cell_ready = (state_q == FILL);
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign row_count      = row_count_q;
    assign busy           = (state_q != IDLE);
    assign frame_done     = frame_done_q;
endmodule

// File: tb/tb_fb_cell_writer.sv
// Directed bench for fb_cell_writer: packing, row wrap, padding, full frame,
// frame_start filtering and mid-frame reset.
module tb_fb_cell_writer;
    logic       clk108      = 1'b0;
    logic       reset_n     = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] row_count;
    logic       busy;
    logic       frame_done;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [19:0] data;
    } wr_t;
    wr_t wq[$];

    fb_cell_writer_if #(.DATA_W(20), .ADDR_W(16)) bus ();

    fb_cell_writer dut (
        .clk108      (clk108),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .bus         (bus),
        .row_count   (row_count),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk108 = ~clk108;

    always @(negedge clk108) begin
        if (bus.wr_en === 1'b1) wq.push_back({bus.wr_addr, bus.wr_data});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic b, input logic last);
        int guard = 0;
        bus.cell_valid = 1'b1;
        bus.cell_bit   = b;
        bus.cell_last  = last;
        while (bus.cell_ready !== 1'b1 && guard < 200) begin
            @(negedge clk108);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed cell_ready=0 for %0d cycles expected 1", guard);
            if (errors > 50) begin
                $display("FAIL too_many_errors: observed %0d expected 0", errors);
                $fatal(1, "abort");
            end
        end
        @(negedge clk108);
        bus.cell_valid = 1'b0;
        bus.cell_last  = 1'b0;
    endtask

    task automatic do_reset();
        bus.cell_valid = 1'b0;
        bus.cell_bit   = 1'b0;
        bus.cell_last  = 1'b0;
        frame_start    = 1'b0;
        reset_n        = 1'b0;
        repeat (2) @(negedge clk108);
        reset_n = 1'b1;
        @(negedge clk108);
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        @(negedge clk108);
        frame_start = 1'b0;
    endtask

    initial begin
        logic prev_wr;
        logic found;

        // Reset state
        do_reset();
        check("rst_ready", bus.cell_ready, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_row_count", row_count, 0);

        // 20 alternating bits starting with 1 -> 0x55555 at address 0
        start_frame();
        check("start_busy", busy, 1);
        wq.delete();
        for (int i = 0; i < 20; i++) send(i % 2 == 0, 1'b0);
        check("alt_wr_en", bus.wr_en, 1);
        check("alt_wr_addr", bus.wr_addr, 0);
        check("alt_wr_data", bus.wr_data, 20'h55555);
        check("alt_ready", bus.cell_ready, 1);
        @(negedge clk108); #1;
        check("alt_wr_count", wq.size(), 1);
        check("alt_wr_en_drop", bus.wr_en, 0);

        // 1280 ones without cell_last wrap into row 1
        do_reset();
        start_frame();
        wq.delete();
        for (int i = 0; i < 1280; i++) send(1'b1, 1'b0);
        @(negedge clk108); #1;
        check("wrap_wr_count", wq.size(), 64);
        for (int i = 0; i < 64 && i < wq.size(); i++) begin
            check($sformatf("wrap_addr_%0d", i), wq[i].addr, i);
            check($sformatf("wrap_data_%0d", i), wq[i].data, 20'hFFFFF);
        end
        check("wrap_row_count", row_count, 1);
        send(1'b1, 1'b1);
        check("wrap_next_wr_en", bus.wr_en, 1);
        check("wrap_next_addr", bus.wr_addr, 64);
        check("wrap_next_data", bus.wr_data, 20'h00001);

        // 45-bit row with cell_last, then zero padding to word 63
        do_reset();
        start_frame();
        wq.delete();
        for (int i = 0; i < 45; i++) send(1'b1, i == 44);
        check("pad_ready_drop", bus.cell_ready, 0);
        check("pad_busy", busy, 1);
        check("pad_wr_en", bus.wr_en, 1);
        check("pad_last_addr", bus.wr_addr, 2);
        check("pad_last_data", bus.wr_data, 20'h0001F);
        repeat (61) @(negedge clk108);
        check("pad_end_addr", bus.wr_addr, 63);
        check("pad_end_data", bus.wr_data, 0);
        check("pad_resume_ready", bus.cell_ready, 1);
        check("pad_row_count", row_count, 1);
        #1;
        check("pad_wr_count", wq.size(), 64);
        if (wq.size() >= 64) begin
            check("pad_w0", wq[0].data, 20'hFFFFF);
            check("pad_w1", wq[1].data, 20'hFFFFF);
            check("pad_w2", wq[2].data, 20'h0001F);
            for (int i = 3; i < 64; i++) begin
                check($sformatf("pad_addr_%0d", i), wq[i].addr, i);
                check($sformatf("pad_zero_%0d", i), wq[i].data, 0);
            end
        end
        send(1'b1, 1'b1);
        check("pad_next_addr", bus.wr_addr, 64);
        check("pad_next_data", bus.wr_data, 20'h00001);

        // Full frame: 1024 single-bit rows
        do_reset();
        start_frame();
        wq.delete();
        for (int r = 0; r < 1024; r++) send(1'b1, 1'b1);
        prev_wr = bus.wr_en;
        found   = 1'b0;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk108);
            if (frame_done === 1'b1) begin
                found = 1'b1;
                break;
            end
            prev_wr = bus.wr_en;
        end
        check("frame_done_seen", found, 1);
        check("frame_done_after_write", prev_wr, 1);
        check("frame_done_no_overlap", bus.wr_en, 0);
        check("frame_busy_low", busy, 0);
        check("frame_last_addr", bus.wr_addr, 16'hFFFF);
        check("frame_last_data", bus.wr_data, 0);
        #1;
        check("frame_wr_count", wq.size(), 65536);
        if (wq.size() == 65536) begin
            check("frame_q_last_addr", wq[65535].addr, 16'hFFFF);
            check("frame_row1023_addr", wq[65472].addr, 16'hFFC0);
            check("frame_row1023_data", wq[65472].data, 20'h00001);
        end
        @(negedge clk108);
        check("frame_done_one_cycle", frame_done, 0);

        // New frame from IDLE after DONE; frame_start in FILL ignored
        start_frame();
        wq.delete();
        for (int i = 0; i < 20; i++) send(1'b1, 1'b0);
        check("restart_addr", bus.wr_addr, 0);
        check("restart_data", bus.wr_data, 20'hFFFFF);
        start_frame();
        for (int i = 0; i < 20; i++) send(1'b1, 1'b0);
        check("ignore_start_addr", bus.wr_addr, 1);
        check("ignore_start_rows", row_count, 0);
        check("ignore_start_busy", busy, 1);

        // Reset after 10 accepted bits of row 5
        do_reset();
        start_frame();
        for (int r = 0; r < 5; r++) send(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) send(1'b1, 1'b0);
        check("mid_row_count", row_count, 5);
        #1;
        wq.delete();
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready", bus.cell_ready, 0);
        check("mid_rst_wr_en", bus.wr_en, 0);
        check("mid_rst_addr", bus.wr_addr, 0);
        check("mid_rst_data", bus.wr_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rows", row_count, 0);
        check("mid_rst_done", frame_done, 0);
        @(negedge clk108);
        reset_n        = 1'b1;
        bus.cell_valid = 1'b1;
        bus.cell_bit   = 1'b1;
        repeat (5) @(negedge clk108);
        #1;
        check("mid_no_write", wq.size(), 0);
        check("mid_idle_busy", busy, 0);
        check("mid_idle_ready", bus.cell_ready, 0);
        bus.cell_valid = 1'b0;
        start_frame();
        for (int i = 0; i < 20; i++) send(1'b0, 1'b0);
        check("post_rst_addr", bus.wr_addr, 0);
        check("post_rst_data", bus.wr_data, 0);
        check("post_rst_wr_en", bus.wr_en, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
